// File: rtl/lcd_pixel_clk_gen.sv
// Pixel-clock generator: divides HCLK by (N+1), emits pixel/phase strobes and a
// registered LCDDCLK; divider settings are shadowed until a period boundary.
module lcd_pixel_clk_gen #(
  parameter int unsigned DIV_W     = 10,
  parameter int unsigned DIV_RST   = 0,
  parameter int unsigned PHASE_RST = 0
) (
  input  logic             HCLK,
  input  logic             HRESETn,
  input  logic             en,
  input  logic [DIV_W-1:0] div_cfg,
  input  logic [DIV_W-1:0] phase_cfg,
  input  logic             inv_clk,
  input  logic             cfg_load,
  output logic             pixel_stb,
  output logic             pixel_stb_ph,
  output logic             LCDDCLK,
  output logic             cfg_busy,
  output logic [DIV_W-1:0] cnt
);

  localparam int unsigned HW = DIV_W + 1;

  logic [DIV_W-1:0] act_div_q, act_phase_q, pend_div_q, pend_phase_q;
  logic             pend_q;

  logic [DIV_W-1:0] cnt_d, act_div_d, act_phase_d, pend_div_d, pend_phase_d;
  logic             pend_d;
  logic             stb_d, stb_ph_d, dclk_d;

  logic [DIV_W-1:0] phase_clamp_c;
  logic             wrap_c;
  logic [HW-1:0]    half_c;

  assign phase_clamp_c = (phase_cfg > div_cfg) ? div_cfg : phase_cfg;
  assign wrap_c        = (cnt == act_div_q);

  // Next-state: config is committed only in idle or on the wrap edge
  always_comb begin
    act_div_d    = act_div_q;
    act_phase_d  = act_phase_q;
    pend_div_d   = pend_div_q;
    pend_phase_d = pend_phase_q;
    pend_d       = pend_q;
    cnt_d        = cnt;

    if (!en || wrap_c) begin
      if (cfg_load) begin
        act_div_d   = div_cfg;
        act_phase_d = phase_clamp_c;
      end else if (pend_q) begin
        act_div_d   = pend_div_q;
        act_phase_d = pend_phase_q;
      end
      pend_d = 1'b0;
    end else if (cfg_load) begin
      pend_div_d   = div_cfg;
      pend_phase_d = phase_clamp_c;
      pend_d       = 1'b1;
    end

    if (!en)         cnt_d = act_div_d;
    else if (wrap_c) cnt_d = '0;
    else             cnt_d = cnt + DIV_W'(1);
  end

  // Outputs derived from next-state count so they line up with cnt
  always_comb begin
    half_c   = (HW'(act_div_d) + HW'(2)) >> 1;
    stb_d    = en && (cnt_d == '0);
    stb_ph_d = en && (cnt_d == act_phase_d);
    dclk_d   = inv_clk ^ (en && (HW'(cnt_d) < half_c));
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      act_div_q    <= DIV_W'(DIV_RST);
      act_phase_q  <= DIV_W'(PHASE_RST);
      pend_div_q   <= '0;
      pend_phase_q <= '0;
      pend_q       <= 1'b0;
      cnt          <= DIV_W'(DIV_RST);
      pixel_stb    <= 1'b0;
      pixel_stb_ph <= 1'b0;
      LCDDCLK      <= 1'b0;
      cfg_busy     <= 1'b0;
    end else begin
      act_div_q    <= act_div_d;
      act_phase_q  <= act_phase_d;
      pend_div_q   <= pend_div_d;
      pend_phase_q <= pend_phase_d;
      pend_q       <= pend_d;
      cnt          <= cnt_d;
      pixel_stb    <= stb_d;
      pixel_stb_ph <= stb_ph_d;
      LCDDCLK      <= dclk_d;
      cfg_busy     <= pend_d;
    end
  end

endmodule
